// File: rtl/tab_pkg.sv
// ============================================================
// tab_pkg : shared constants and state encoding for tab_div7
// Revision : 1.0
// ============================================================
`default_nettype none

package tab_pkg;

  localparam int TAB_SQ_W = 7;
  localparam int TAB_Q_W  = 5;
  localparam int TAB_R_W  = 3;
  localparam int TAB_REM_W = 4;
  localparam int TAB_CNT_W = 3;

  localparam logic [TAB_REM_W-1:0] TAB_DIVISOR  = 4'd7;
  localparam logic [TAB_Q_W-1:0]   TAB_N_MAX    = 5'd9;
  localparam logic [TAB_CNT_W-1:0] TAB_CNT_INIT = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tab_state_e;

  // A code word is valid only when it is 7*n with n inside the table.
  function automatic logic tab_range_err(input logic [TAB_Q_W-1:0] q,
                                         input logic [TAB_R_W-1:0] r);
    return (q > TAB_N_MAX) || (r != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tab_div7_step.sv
// ============================================================
// tab_div7_step : one combinational restoring-division step by 7
// Revision : 1.0
// ============================================================
`default_nettype none

module tab_div7_step
  import tab_pkg::*;
(
  input  logic [TAB_REM_W-1:0] rem,
  input  logic                 din,
  output logic [TAB_REM_W-1:0] rem_next,
  output logic                 qbit
);

  logic [TAB_REM_W:0]   shifted;
  logic [TAB_REM_W-1:0] diff;

  // rem is always below 7, so the top bit of shifted is zero in practice.
  always_comb begin
    shifted  = {rem, din};
    diff     = shifted[TAB_REM_W-1:0] - TAB_DIVISOR;
    qbit     = (shifted >= {1'b0, TAB_DIVISOR});
    rem_next = qbit ? diff : shifted[TAB_REM_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/tab_div7.sv
// ============================================================
// tab_div7 : serial restoring divider by 7 for table code words.
// TAB_DIV7_RANGE_CHK_EN enables the registered err flag.
// Revision : 1.0
// ============================================================
`default_nettype none

module tab_div7
  import tab_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [TAB_SQ_W-1:0] sq,
  output logic                busy,
  output logic                done,
  output logic [TAB_Q_W-1:0]  q,
  output logic [TAB_R_W-1:0]  r,
  output logic                exact,
  output logic                err
);

  tab_state_e           state;
  logic [TAB_CNT_W-1:0] cnt;
  logic [TAB_SQ_W-1:0]  dividend;
  logic [TAB_REM_W-1:0] rem;
  logic [TAB_Q_W-1:0]   qacc;

  logic [TAB_REM_W-1:0] step_rem;
  logic                 step_q;
  logic [TAB_Q_W-1:0]   q_weight;
  logic [TAB_Q_W-1:0]   q_next;
  logic [TAB_R_W-1:0]   r_fin;

  tab_div7_step u_step (
    .rem      (rem),
    .din      (dividend[TAB_SQ_W-1]),
    .rem_next (step_rem),
    .qbit     (step_q)
  );

  // Quotient bits for positions 6 and 5 are provably zero, so only 0..4 are kept.
  always_comb begin
    q_weight = '0;
    if (step_q && (cnt < TAB_CNT_W'(TAB_Q_W))) begin
      q_weight = TAB_Q_W'(1) << cnt;
    end
    q_next = qacc | q_weight;
    r_fin  = step_rem[TAB_R_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dividend <= '0;
      rem      <= '0;
      qacc     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      r        <= '0;
      exact    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            dividend <= sq;
            rem      <= '0;
            qacc     <= '0;
            cnt      <= TAB_CNT_INIT;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          dividend <= {dividend[TAB_SQ_W-2:0], 1'b0};
          rem      <= step_rem;
          qacc     <= q_next;
          if (cnt == '0) begin
            state <= ST_DONE;
            q     <= q_next;
            r     <= r_fin;
            exact <= (r_fin == '0);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TAB_DIV7_RANGE_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((state == ST_RUN) && (cnt == '0)) begin
      err <= tab_range_err(q_next, r_fin);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/tab_div7.md
TAB_DIV7 -- requirements
Module: tab_div7

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 start  input  1  request to divide sq; sampled only in IDLE.
REQ-004 sq  input  7  multiplication-table code word (7*n for n 0..9 when valid); sampled with start.
REQ-005 busy  output  1  high in RUN and DONE.
REQ-006 done  output  1  single-cycle pulse; results valid.
REQ-007 q  output  5  quotient floor(sq/7), range 0..18.
REQ-008 r  output  3  remainder sq mod 7, range 0..6.
REQ-009 exact  output  1  r == 0.
REQ-010 err  output  1  code word outside table (q > 9 or r != 0); present only per REQ-024.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN: start=1; sq captured, partial remainder cleared, bit counter=6.
- RUN: one restoring-division step per cycle, MSB first.
- RUN->DONE: after the 7th step.
- DONE->IDLE: unconditionally, next edge.
REQ-012 Each RUN step SHALL form rem' = {rem[2:0], dividend bit}. If rem' >= 7: subtract 7, quotient bit = 1; else keep rem', bit = 0.
REQ-013 The partial remainder SHALL be held in 4 bits, the quotient in 5 bits, with no overflow for any sq 0..127.
REQ-014 Latency SHALL be fixed: with start sampled at edge k, done SHALL be high exactly in the cycle following edge k+8.
REQ-015 q, r, exact and err SHALL update only on the RUN->DONE edge. They SHALL hold until the next completed operation.
REQ-016 start SHALL be ignored while busy=1, including in DONE. sq changes during RUN SHALL NOT affect the result.
REQ-017 done SHALL be high for exactly one cycle per accepted start.
REQ-018 Back-to-back: start held high SHALL be accepted in the IDLE cycle after DONE. Throughput is one result per 9 cycles.
REQ-019 The sq values 0,7,...,63 SHALL return q = n, r = 0, exact = 1.

Reset
REQ-020 rst_n low SHALL force state IDLE immediately, regardless of clk.
REQ-021 Reset SHALL clear the bit counter, working registers, busy, done, q, r and err, and SHALL set exact to 1.
REQ-022 Reset during RUN or DONE SHALL abort the operation with no done pulse.
REQ-023 The first start after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-024 Macro TAB_DIV7_RANGE_CHK_EN:
- defined: err is registered on the RUN->DONE edge as (q > 9) or (r != 0).
- undefined: err is constant 0 and no comparison logic is built.
- The port exists in both builds.

Structure
REQ-025 Shared package tab_pkg SHALL hold:
- constants TAB_DIVISOR = 7, TAB_SQ_W = 7, TAB_Q_W = 5, TAB_R_W = 3, TAB_N_MAX = 9;
- the IDLE/RUN/DONE state encoding.
REQ-026 One sub-module tab_div7_step SHALL implement the combinational single-step compare/subtract of REQ-012. tab_div7 instantiates it once and owns all registers.

Verification
REQ-027 sq=63, start pulse -> done high exactly in the cycle after edge k+8; q=9, r=0, exact=1, err=0.
REQ-028 sq=64 -> q=9, r=1, exact=0, err=1 (err=0 when the macro is undefined).
REQ-029 sq=127 -> q=18, r=1, err=1. Then sq=0 -> q=0, r=0, exact=1, err=0.
REQ-030 sq=21 started; start re-pulsed with sq=70 during RUN and DONE -> single done, q=3, r=0; second request dropped.
REQ-031 rst_n low at 3rd RUN cycle -> busy=0, q=0, r=0, exact=1 and no done. Later sq=14 -> q=2, r=0 with nominal latency.
REQ-032 start held high with sq=35 -> done pulses every 9 cycles, each with q=5, r=0.
